// File: rtl/fetch_if.sv
// Handshake and program-load bundle between the fetch sequencer, its host and the bitty core.
interface fetch_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              stop;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [15:0]       prog_data;
   logic [ADDR_W:0]   prog_len;
   logic              done;
   logic [15:0]       d_out;
   logic              run;
   logic [15:0]       d_instr;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic [15:0]       last_result;
   logic [15:0]       instr_count;

   modport master (
      input  start, stop, prog_we, prog_addr, prog_data, prog_len, done, d_out,
      output run, d_instr, pc, busy, halted, last_result, instr_count
   );

   modport slave (
      output start, stop, prog_we, prog_addr, prog_data, prog_len, done, d_out,
      input  run, d_instr, pc, busy, halted, last_result, instr_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction sequencer: walks a loadable program memory, issues each word to the core
// with a one-cycle run pulse and collects the result on done.
module fetch_unit #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned LOOP      = 0
) (
   input logic    clk,
   input logic    reset,
   fetch_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;

   localparam logic [ADDR_W:0] LEN_ONE = 1;

   state_t            state;
   logic              stop_q;
   logic [15:0]       mem [MEM_DEPTH];
   logic              run_r;
   logic [15:0]       d_instr_r;
   logic [ADDR_W-1:0] pc_r;
   logic              busy_r;
   logic              halted_r;
   logic [15:0]       last_result_r;
   logic [15:0]       instr_count_r;

   logic can_start;
   logic at_end;
   logic wr_ok;

   assign can_start = bus.start && (bus.prog_len != '0);
   assign at_end    = ({1'b0, pc_r} == (bus.prog_len - LEN_ONE));
   assign wr_ok     = (state == S_IDLE) || (state == S_HALT);

   always_ff @(posedge clk) begin
      if (bus.prog_we && wr_ok) mem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         stop_q        <= 1'b0;
         run_r         <= 1'b0;
         d_instr_r     <= '0;
         pc_r          <= '0;
         busy_r        <= 1'b0;
         halted_r      <= 1'b0;
         last_result_r <= '0;
         instr_count_r <= '0;
      end else begin
         run_r <= 1'b0;
         if (bus.stop && (state inside {S_FETCH, S_ISSUE, S_WAIT})) stop_q <= 1'b1;
         case (state)
            S_IDLE, S_HALT: begin
               stop_q <= 1'b0;
               if (can_start) begin
                  pc_r          <= '0;
                  instr_count_r <= '0;
                  busy_r        <= 1'b1;
                  halted_r      <= 1'b0;
                  state         <= S_FETCH;
               end
            end
            S_FETCH: begin
               d_instr_r <= mem[pc_r];
               run_r     <= 1'b1;
               state     <= S_ISSUE;
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (bus.done) begin
                  last_result_r <= bus.d_out;
                  if (instr_count_r != '1) instr_count_r <= instr_count_r + 16'd1;
                  // A stop request outranks the end-of-program test; both halt with pc held.
                  if (stop_q || bus.stop || (at_end && LOOP == 0)) begin
                     stop_q   <= 1'b0;
                     busy_r   <= 1'b0;
                     halted_r <= 1'b1;
                     state    <= S_HALT;
                  end else begin
                     pc_r  <= at_end ? '0 : pc_r + ADDR_W'(1);
                     state <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.run         = run_r;
   assign bus.d_instr     = d_instr_r;
   assign bus.pc          = pc_r;
   assign bus.busy        = busy_r;
   assign bus.halted      = halted_r;
   assign bus.last_result = last_result_r;
   assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model of the non-looping instance checked every
// cycle, a looping instance checked with directed expectations, and a simple core responder.
module tb_fetch_unit;
   localparam int unsigned AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_if #(.ADDR_W(AW)) b0 ();
   fetch_if #(.ADDR_W(AW)) b1 ();

   fetch_unit #(.ADDR_W(AW), .MEM_DEPTH(256), .LOOP(0)) dut0 (.clk(clk), .reset(rst_n), .bus(b0.master));
   fetch_unit #(.ADDR_W(AW), .MEM_DEPTH(256), .LOOP(1)) dut1 (.clk(clk), .reset(rst_n), .bus(b1.master));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Core responders: done (with d_out = instr+1) four cycles after run, or done held high.
   logic        hold0 = 1'b0;
   logic [15:0] hold_val0 = '0;
   int          cnt0 = 0, cnt1 = 0;
   logic [15:0] ins0 = '0, ins1 = '0;

   always @(negedge clk) begin
      if (hold0) begin
         b0.done = 1'b1; b0.d_out = hold_val0; cnt0 = 0;
      end else begin
         b0.done = 1'b0;
         if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin b0.done = 1'b1; b0.d_out = ins0 + 16'd1; end
         end
         if (b0.run) begin cnt0 = 4; ins0 = b0.d_instr; end
      end
   end

   always @(negedge clk) begin
      b1.done = 1'b0;
      if (cnt1 > 0) begin
         cnt1--;
         if (cnt1 == 0) begin b1.done = 1'b1; b1.d_out = ins1 + 16'd1; end
      end
      if (b1.run) begin cnt1 = 4; ins1 = b1.d_instr; end
   end

   // Observation monitors
   int          runs0 = 0, dbl0 = 0, halts1 = 0;
   logic [15:0] instrs0[$];
   logic [7:0]  pcs1[$];
   logic        prev_run0 = 1'b0;
   always @(negedge clk) begin
      if (b0.run) begin runs0++; instrs0.push_back(b0.d_instr); end
      if (b0.run && prev_run0) dbl0++;
      prev_run0 = b0.run;
      if (b1.run) pcs1.push_back(b1.pc);
      if (b1.halted) halts1++;
   end

   // Model of the LOOP=0 instance: program running, instruction outstanding, issue countdown.
   logic [15:0] m_mem [256];
   bit          m_running, m_out, m_run, m_halted, m_stop;
   int          m_due;
   logic [7:0]  m_pc;
   logic [15:0] m_last, m_count;

   always @(posedge clk or negedge rst_n) begin
      bit prev_run;
      if (!rst_n) begin
         m_running = 0; m_out = 0; m_run = 0; m_halted = 0; m_stop = 0;
         m_due = 0; m_pc = '0; m_last = '0; m_count = '0;
      end else begin
         prev_run = m_run;
         m_run = 0;
         if (m_due > 0) begin m_due--; if (m_due == 0) m_run = 1; end
         if (!m_running && b0.prog_we) m_mem[b0.prog_addr] = b0.prog_data;
         if (m_running && b0.stop) m_stop = 1;
         if (m_out && b0.done) begin
            m_out = 0;
            m_last = b0.d_out;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (m_stop || int'(m_pc) == int'(b0.prog_len) - 1) begin
               m_running = 0; m_halted = 1; m_stop = 0;
            end else begin
               m_pc = m_pc + 8'd1; m_due = 1;
            end
         end
         if (prev_run) m_out = 1;
         if (!m_running && b0.start && b0.prog_len != 0) begin
            m_running = 1; m_halted = 0; m_pc = '0; m_count = '0; m_due = 1; m_stop = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("run", b0.run, m_run);
         chk("busy", b0.busy, m_running);
         chk("halted", b0.halted, m_halted);
         chk("pc", b0.pc, m_pc);
         chk("last_result", b0.last_result, m_last);
         chk("instr_count", b0.instr_count, m_count);
         if (m_run || m_out) chk("d_instr", b0.d_instr, m_mem[m_pc]);
      end
   end

   task automatic load(input int sel, input logic [7:0] a, input logic [15:0] d);
      if (sel == 0) begin b0.prog_we = 1; b0.prog_addr = a; b0.prog_data = d; end
      else          begin b1.prog_we = 1; b1.prog_addr = a; b1.prog_data = d; end
      @(negedge clk);
      b0.prog_we = 0; b1.prog_we = 0;
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 0) b0.start = 1; else b1.start = 1;
      @(negedge clk);
      b0.start = 0; b1.start = 0;
   endtask

   task automatic wait_run0(input string nm);
      for (int i = 0; i < 50 && !b0.run; i++) @(negedge clk);
      chk(nm, b0.run, 1);
   endtask

   task automatic wait_halt0(input string nm);
      for (int i = 0; i < 200 && !b0.halted; i++) @(negedge clk);
      chk(nm, b0.halted, 1);
   endtask

   initial begin
      int base;
      b0.start = 0; b0.stop = 0; b0.prog_we = 0; b0.prog_addr = '0; b0.prog_data = '0; b0.prog_len = '0;
      b1.start = 0; b1.stop = 0; b1.prog_we = 0; b1.prog_addr = '0; b1.prog_data = '0; b1.prog_len = '0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_pc", b0.pc, 0);
      chk("rst_run", b0.run, 0);
      chk("rst_busy", b0.busy, 0);
      chk("rst_halted", b0.halted, 0);
      chk("rst_d_instr", b0.d_instr, 0);
      chk("rst_count", b0.instr_count, 0);

      // three-instruction program, no loop
      load(0, 8'd0, 16'h1111); load(0, 8'd1, 16'h2222); load(0, 8'd2, 16'h3333);
      b0.prog_len = 9'd3;
      base = runs0;
      pulse_start(0);
      wait_halt0("t1_halt");
      chk("t1_runs", runs0 - base, 3);
      chk("t1_i0", instrs0[base], 16'h1111);
      chk("t1_i1", instrs0[base+1], 16'h2222);
      chk("t1_i2", instrs0[base+2], 16'h3333);
      chk("t1_pc", b0.pc, 2);
      chk("t1_last", b0.last_result, 16'h3334);
      chk("t1_count", b0.instr_count, 3);

      // looping instance, two instructions, five completions
      load(1, 8'd0, 16'hAAAA); load(1, 8'd1, 16'hBBBB);
      b1.prog_len = 9'd2;
      pulse_start(1);
      for (int i = 0; i < 300 && b1.instr_count != 16'd5; i++) @(negedge clk);
      chk("t2_count", b1.instr_count, 5);
      chk("t2_halts", halts1, 0);
      chk("t2_nruns", pcs1.size() >= 5, 1);
      if (pcs1.size() >= 5) begin
         chk("t2_pc0", pcs1[0], 0); chk("t2_pc1", pcs1[1], 1); chk("t2_pc2", pcs1[2], 0);
         chk("t2_pc3", pcs1[3], 1); chk("t2_pc4", pcs1[4], 0);
      end
      b1.stop = 1; @(negedge clk); b1.stop = 0;

      // stop during the WAIT of the first instruction
      base = runs0;
      pulse_start(0);
      wait_run0("t3_run");
      @(negedge clk);
      b0.stop = 1; @(negedge clk); b0.stop = 0;
      wait_halt0("t3_halt");
      repeat (10) @(negedge clk);
      chk("t3_pc", b0.pc, 0);
      chk("t3_count", b0.instr_count, 1);
      chk("t3_last", b0.last_result, 16'h1112);
      chk("t3_runs", runs0 - base, 1);

      // done held high before and throughout execution
      hold_val0 = 16'h5A5A; hold0 = 1;
      repeat (3) @(negedge clk);
      chk("t4_idle_count", b0.instr_count, 1);
      base = runs0;
      pulse_start(0);
      wait_halt0("t4_halt");
      chk("t4_runs", runs0 - base, 3);
      chk("t4_count", b0.instr_count, 3);
      chk("t4_last", b0.last_result, 16'h5A5A);
      chk("t4_run_width", dbl0, 0);
      hold0 = 0;
      @(negedge clk);

      // asynchronous reset in the middle of WAIT, then a late done
      pulse_start(0);
      wait_run0("t6_run");
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("t6_run", b0.run, 0);
      chk("t6_busy", b0.busy, 0);
      chk("t6_pc", b0.pc, 0);
      chk("t6_d_instr", b0.d_instr, 0);
      chk("t6_last", b0.last_result, 0);
      chk("t6_count", b0.instr_count, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (8) @(negedge clk);
      chk("t6_late_count", b0.instr_count, 0);
      chk("t6_late_busy", b0.busy, 0);

      // zero-length start ignored; writes while busy ignored
      b0.prog_len = '0;
      base = runs0;
      pulse_start(0);
      repeat (3) @(negedge clk);
      chk("t5_busy", b0.busy, 0);
      chk("t5_halted", b0.halted, 0);
      chk("t5_runs", runs0 - base, 0);
      b0.prog_len = 9'd1;
      pulse_start(0);
      wait_run0("t5_run");
      @(negedge clk);
      load(0, 8'd0, 16'hDEAD);
      wait_halt0("t5_halt");
      base = runs0;
      pulse_start(0);
      wait_run0("t5_rb_run");
      chk("t5_readback", b0.d_instr, 16'h1111);
      wait_halt0("t5_rb_halt");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
